// File: rtl/nn_arith_pkg.sv
// Shared arithmetic definitions for the neuron datapath: op-mode encoding,
// chunk sizing and the WIDTH/STAGES legality rule.
package nn_arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

endpackage

`define NN_ARITH_LEGAL(W, S) (((W) >= 2) && ((S) >= 1) && ((S) <= (W)) && (((W) % (S)) == 0))

// File: rtl/adder_chunk.sv
// Combinational CW-bit adder slice with carry-in; also reports the carry
// into its MSB so the top slice can derive signed overflow.
module adder_chunk #(
    parameter int unsigned CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [CW:0] full;

    assign full = {1'b0, a} + {1'b0, b} + (CW+1)'(cin);
    assign sum  = full[CW-1:0];
    assign cout = full[CW];
    // carry into bit CW-1 recovered from its sum bit
    assign cmsb = a[CW-1] ^ b[CW-1] ^ full[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit, carry-chained over STAGES chunks with one chunk
// per clock; valid/ready on both sides with a single global advance.
module pipelined_adder
    import nn_arith_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int unsigned CW    = chunk_w(WIDTH, STAGES);
    localparam bit          LEGAL = `NN_ARITH_LEGAL(WIDTH, STAGES);

    if (!LEGAL) begin : g_illegal
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic             adv;
    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // inputs seen by each stage (stage 0 from ports, others from previous stage)
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];

    logic [CW-1:0]    ch_s  [STAGES];
    logic             ch_co [STAGES];
    logic             ch_cm [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    assign adv      = ~v_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    assign op    = op_e'(in_sub);
    assign b_eff = (op == OP_SUB) ? ~in_b : in_b;
    assign cin0  = (op == OP_SUB) ? 1'b1 : in_cin;

    // stage feeds: full operand words travel along so later chunks stay skewed
    always_comb begin
        st_a[0] = in_a;
        st_b[0] = b_eff;
        st_s[0] = '0;
        st_c[0] = cin0;
        st_v[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_chunk
        adder_chunk #(
            .CW (CW)
        ) u_chunk (
            .a    (st_a[g][g*CW +: CW]),
            .b    (st_b[g][g*CW +: CW]),
            .cin  (st_c[g]),
            .sum  (ch_s[g]),
            .cout (ch_co[g]),
            .cmsb (ch_cm[g])
        );
    end

    // merge each stage's fresh chunk into the partial result travelling with the op
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_s[k]               = st_s[k];
            nxt_s[k][k*CW +: CW]   = ch_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= st_v[k];
                a_q[k] <= st_a[k];
                b_q[k] <= st_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= ch_co[k];
            end
            ovf_q <= ch_cm[STAGES-1] ^ ch_co[STAGES-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;

endmodule
